// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one fifo write port between N_REQ producers.
// Each written beat is tagged with the ID of the producer that sourced it.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_REQ    = 4,
  localparam int unsigned ID_WIDTH = $clog2(N_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]      fifo_wr_id,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic [ID_WIDTH-1:0]      owner
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic [ID_WIDTH-1:0] winner;
  logic                winner_found;
  logic                own_valid;
  logic                own_last;
  logic [WIDTH-1:0]    own_data;

  // First requester scanning upward from last_grant+1, wrapping at N_REQ.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      logic [ID_WIDTH-1:0] idx;
      idx = ID_WIDTH'((32'(last_grant_q) + k) % N_REQ);
      if (!winner_found && req_valid[idx]) begin
        winner_found = 1'b1;
        winner       = idx;
      end
    end
  end

  // Select the owner's request lines.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == ID_WIDTH'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Write-port outputs; data and ID are zero whenever no beat is written.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    fifo_wr_id   = '0;
    if (state_q == ST_LOCKED) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        req_ready[i] = (owner_q == ID_WIDTH'(i)) && !fifo_full;
      end
      fifo_wr_en = own_valid && !fifo_full;
      if (fifo_wr_en) begin
        fifo_wr_data = own_data;
        fifo_wr_id   = owner_q;
      end
    end
  end

  // Next-state logic: grant in IDLE, release on the transferred last beat.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (winner_found) begin
          owner_d = winner;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (fifo_wr_en && own_last) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= ID_WIDTH'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy  = (state_q == ST_LOCKED);
  assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packets with hand-ordered expected writes.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_last  = '0;
  logic [127:0] req_data  = '0;
  logic [3:0]   req_ready;
  logic [31:0]  fifo_wr_data;
  logic [1:0]   fifo_wr_id;
  logic         fifo_wr_en;
  logic         fifo_full = 1'b0;
  logic         busy;
  logic [1:0]   owner;

  fifo_wr_arbiter #(.WIDTH(32), .N_REQ(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_id(fifo_wr_id), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  bit mon_en = 1'b0;

  beat_t       src_q[4][$];
  logic [33:0] exp_q[$];
  logic [3:0]  hold = '0;

  logic        s_en, s_busy;
  logic [1:0]  s_owner, s_id;
  logic [3:0]  s_ready;
  logic [31:0] s_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_pkt(input int id, input int len, input logic [31:0] base);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.d = base + 32'(b);
      bt.l = (b == len - 1);
      src_q[id].push_back(bt);
    end
  endtask

  task automatic exp_pkt(input int id, input int len, input logic [31:0] base);
    for (int b = 0; b < len; b++) exp_q.push_back({2'(id), base + 32'(b)});
  endtask

  // One clock: drive at posedge+1, snapshot at negedge, retire accepted beats.
  task automatic tick();
    logic [3:0] acc;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src_q[i][0].l;
        req_data[i*32 +: 32]  = src_q[i][0].d;
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*32 +: 32]  = 32'hDEAD_0000 | 32'(i);
      end
    end
    @(negedge clock);
    s_en = fifo_wr_en; s_busy = busy; s_owner = owner;
    s_ready = req_ready; s_data = fifo_wr_data; s_id = fifo_wr_id;
    acc = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(src_q[i].pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit sources_empty();
    for (int i = 0; i < 4; i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input bit rand_full);
    int n = 0;
    while ((exp_q.size() > 0 || !sources_empty()) && n < 400) begin
      fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      n++;
    end
    fifo_full = 1'b0;
    chk({nm, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en) begin
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {30'd0, fifo_wr_id, fifo_wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("write_beat", {30'd0, fifo_wr_id, fifo_wr_data}, {30'd0, e});
        end
      end else begin
        chk("idle_zero", {30'd0, fifo_wr_id, fifo_wr_data}, 64'd0);
      end
      if (fifo_full) chk("no_write_full", 64'(fifo_wr_en), 64'd0);
      if (req_ready != 4'd0) chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
    end
  end

  initial begin
    do_reset();
    mon_en = 1'b1;

    // Reset values.
    tick();
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_en", 64'(s_en), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_owner", 64'(s_owner), 64'd0);
    chk("rst_data_id", {30'd0, s_id, s_data}, 64'd0);

    // Single producer, three beats: one IDLE cycle then A0..A2.
    add_pkt(0, 3, 32'hA0);
    exp_pkt(0, 3, 32'hA0);
    tick();
    chk("t1_c1_en", 64'(s_en), 64'd0);
    chk("t1_c1_busy", 64'(s_busy), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("t1_beat_en", 64'(s_en), 64'd1);
      chk("t1_beat_id", 64'(s_id), 64'd0);
    end
    tick();
    chk("t1_c5_busy", 64'(s_busy), 64'd0);
    chk("t1_done", 64'(exp_q.size()), 64'd0);

    // All four send one-beat packets from reset: order 0,1,2,3,0,1,2,3; write every other cycle.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        add_pkt(i, 1, 32'hB000_0000 | 32'(i << 4) | 32'(r));
        exp_pkt(i, 1, 32'hB000_0000 | 32'(i << 4) | 32'(r));
      end
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t2_cadence", 64'(s_en), 64'(k % 2 == 0));
    end
    chk("t2_done", 64'(exp_q.size()), 64'd0);

    // Owner 2 stalled by fifo_full for 3 cycles; 3 then 0 follow.
    add_pkt(2, 4, 32'hC0);
    exp_pkt(2, 4, 32'hC0);
    tick();
    chk("t3_grant", 64'(s_en), 64'd0);
    add_pkt(0, 1, 32'hD0);
    add_pkt(3, 1, 32'hE0);
    exp_pkt(3, 1, 32'hE0);
    exp_pkt(0, 1, 32'hD0);
    tick();
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_full_en", 64'(s_en), 64'd0);
      chk("t3_full_ready", 64'(s_ready), 64'd0);
      chk("t3_full_owner", 64'(s_owner), 64'd2);
      chk("t3_full_busy", 64'(s_busy), 64'd1);
    end
    fifo_full = 1'b0;
    drain("t3", 1'b0);

    // Owner 1 drops valid for 2 cycles; requester 3 waits for 1's last beat.
    add_pkt(1, 3, 32'h10);
    exp_pkt(1, 3, 32'h10);
    tick();
    add_pkt(3, 1, 32'h30);
    exp_pkt(3, 1, 32'h30);
    tick();
    hold[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t4_owner", 64'(s_owner), 64'd1);
      chk("t4_busy", 64'(s_busy), 64'd1);
      chk("t4_en", 64'(s_en), 64'd0);
      chk("t4_ready3", 64'(s_ready[3]), 64'd0);
    end
    hold[1] = 1'b0;
    drain("t4", 1'b0);

    // Reset while owner 3 is mid-packet; afterwards 0 beats 3.
    add_pkt(3, 4, 32'hF0);
    exp_pkt(3, 2, 32'hF0);
    tick();
    tick();
    tick();
    chk("t5_owner", 64'(s_owner), 64'd3);
    chk("t5_busy", 64'(s_busy), 64'd1);
    do_reset();
    tick();
    chk("t5_rst_busy", 64'(s_busy), 64'd0);
    chk("t5_rst_ready", 64'(s_ready), 64'd0);
    chk("t5_rst_en", 64'(s_en), 64'd0);
    chk("t5_rst_owner", 64'(s_owner), 64'd0);
    add_pkt(0, 1, 32'h900);
    add_pkt(3, 1, 32'h930);
    exp_pkt(0, 1, 32'h900);
    exp_pkt(3, 1, 32'h930);
    drain("t5", 1'b0);

    // All producers saturated with mixed lengths under random full: strict round-robin order.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) begin
        add_pkt(i, 1 + ((i + r) % 3), {8'(i), 8'(r), 16'h5A00});
        exp_pkt(i, 1 + ((i + r) % 3), {8'(i), 8'(r), 16'h5A00});
      end
    drain("t6", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
